alu_acc_stage: RTL and testbench
================================

# alu_acc_stage

Accumulator and issue stage wrapped around the processor's combinational 14-bit ALU. Accepts one instruction (3-bit op plus 14-bit signed operand, already carrying the ×100 fixed-point gain) over a valid/ready handshake. Drives the ALU with the registered operand on `in1`, the accumulator on `in2` (the feedback path) and the registered op. Captures the result back into the accumulator and raises status flags.

## Interface
- `W`, 14, data width of operand, accumulator and ALU ports (signed)
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous active-low reset
- `instr_valid` in 1: instruction present
- `instr_ready` out 1: stage can accept; high only in IDLE
- `instr_op` in 3: ALU op code (000 add, 001 sub, 010 mul, 011 div, 100 load, 101 set, 110 equ, 111 nop)
- `instr_imm` in W: signed operand
- `alu_in1` out W: registered operand to ALU
- `alu_in2` out W: combinational copy of `acc`
- `alu_op` out 3: registered op to ALU
- `alu_out` in W: ALU result, combinational from `alu_in1`/`alu_in2`/`alu_op`
- `acc` out W: accumulator
- `res_valid` out 1: one-cycle pulse, instruction retired
- `flag_zero` out 1: `acc == 0` after last retire
- `flag_eq` out 1: result of last EQU
- `flag_dz` out 1: last instruction was a guarded divide by zero

## Operation
- FSM states:
  - IDLE: `instr_ready`=1; on `instr_valid` load `alu_in1`←`instr_imm`, `alu_op`←`instr_op`, go to EXEC.
  - EXEC: `alu_out` is settled; apply write-back rule at the edge, go to DONE.
  - DONE: `res_valid`=1, `instr_ready`=0; go to IDLE.
- Write-back rules at the EXEC edge:
  - Ops 000–100: `acc`←`alu_out`; `flag_zero`←(`alu_out`==0); `flag_dz`←0.
  - 101 (set): `acc` unchanged (ALU returns `in2`); flags updated as above.
  - 110 (equ): `acc` unchanged; `flag_eq`←`alu_out[0]`; `flag_zero` unchanged.
  - 111 (nop): nothing written; `alu_op` driven 101 so the ALU never sees an undefined code; still retires with `res_valid`.
  - `flag_eq` is written only by 110.
- Arithmetic, width and scaling are entirely the ALU's. This stage does no scaling and no extension; the ALU's W-bit signed result is stored as is, with two's-complement wrap.
- `instr_op`/`instr_imm` are ignored outside IDLE. The upstream must hold them stable while `instr_valid` is high and `instr_ready` is low.
- Reset (asynchronous, any state including mid-EXEC):
  - state IDLE; `acc`=0, `alu_in1`=0, `alu_op`=101.
  - `res_valid`=0, `flag_eq`=0, `flag_dz`=0, `flag_zero`=1.
  - An instruction in flight is discarded without retiring.

## Timing
- Accept at edge N (valid & ready).
- `acc`/flags update at edge N+1.
- `res_valid` high during cycle N+1→N+2.
- `instr_ready` returns high after edge N+2.
- Throughput: one instruction per 3 cycles.
- `alu_in2` follows `acc` with zero latency.
- All outputs except `alu_in2` are registered.

## Configuration
- `ACC_DZ_GUARD_EN` defined:
  - Op 011 with `instr_imm`==0 is detected in IDLE and `alu_op` is loaded as 101, so the ALU passes `acc` through.
  - At EXEC, `acc` and `flag_zero` are unchanged and `flag_dz`←1; the instruction still retires.
- Not defined:
  - `flag_dz` is tied 0 and division by zero is forwarded to the ALU.
  - `acc` takes whatever `alu_out` returns; the result is undefined and not checked by the bench.

## Test plan
- Reset, then op 100 imm 250 → at N+1 `acc`=250, `flag_zero`=0; `res_valid` pulse at N+1 only.
- `acc`=250, op 010 imm 200 → `acc`=500. Then op 011 imm 250 → `acc`=200. Then op 001 imm 200 → `acc`=0, `flag_zero`=1.
- `acc`=500, op 110 imm 500 → `flag_eq`=1, `acc`=500. Then op 110 imm 100 → `flag_eq`=0.
- With `ACC_DZ_GUARD_EN`: `acc`=300, op 011 imm 0 → `acc`=300, `flag_dz`=1. Next op 000 imm 5 → `acc`=305, `flag_dz`=0.
- Back-to-back: `instr_valid` held high with two queued instructions → `instr_ready` low for 2 cycles; second accept exactly 3 cycles after the first; no instruction lost or duplicated.
- Assert `rst_n` low during EXEC of op 000 imm 7 with `acc`=100 → `acc`=0 immediately, no `res_valid`, `instr_ready`=1 after release.

Source files
------------

// File: rtl/alu_acc_stage.sv
// alu_acc_stage: accumulator / issue stage around an external combinational ALU.
// One instruction is accepted in IDLE, executed against the accumulator in EXEC,
// and retired with a one-cycle res_valid pulse in DONE (3 cycles per instruction).
// Optional feature macro: ACC_DZ_GUARD_EN (guards divide-by-zero in this stage).
module alu_acc_stage #(
  parameter int W = 14
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         instr_valid,
  output logic         instr_ready,
  input  logic [2:0]   instr_op,
  input  logic [W-1:0] instr_imm,
  output logic [W-1:0] alu_in1,
  output logic [W-1:0] alu_in2,
  output logic [2:0]   alu_op,
  input  logic [W-1:0] alu_out,
  output logic [W-1:0] acc,
  output logic         res_valid,
  output logic         flag_zero,
  output logic         flag_eq,
  output logic         flag_dz
);

  localparam logic [2:0] OP_DIV  = 3'b011;
  localparam logic [2:0] OP_LOAD = 3'b100;
  localparam logic [2:0] OP_SET  = 3'b101;
  localparam logic [2:0] OP_EQU  = 3'b110;
  localparam logic [2:0] OP_NOP  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] in1_q, in1_d;
  logic [2:0]   op_q, op_d;      // code presented to the ALU
  logic [2:0]   opr_q, opr_d;    // original op, selects the write-back rule
  logic         dz_q, dz_d;      // instruction was a guarded divide by zero
  logic [W-1:0] acc_q, acc_d;
  logic         ready_q, ready_d;
  logic         res_valid_q, res_valid_d;
  logic         fz_q, fz_d;
  logic         feq_q, feq_d;
  logic         fdz_q, fdz_d;

  // Next-state, operand capture and write-back
  always_comb begin
    state_d     = state_q;
    in1_d       = in1_q;
    op_d        = op_q;
    opr_d       = opr_q;
    dz_d        = dz_q;
    acc_d       = acc_q;
    res_valid_d = 1'b0;
    fz_d        = fz_q;
    feq_d       = feq_q;
    fdz_d       = fdz_q;
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          in1_d   = instr_imm;
          opr_d   = instr_op;
          dz_d    = 1'b0;
          // nop must never reach the ALU as an undefined code
          op_d    = (instr_op == OP_NOP) ? OP_SET : instr_op;
`ifdef ACC_DZ_GUARD_EN
          // divide by zero: let the ALU pass acc through instead
          if (instr_op == OP_DIV && instr_imm == '0) begin
            op_d = OP_SET;
            dz_d = 1'b1;
          end
`endif
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        res_valid_d = 1'b1;
        state_d     = S_DONE;
        if (dz_q) begin
          fdz_d = 1'b1;
        end else if (opr_q <= OP_LOAD) begin
          acc_d = alu_out;
          fz_d  = (alu_out == '0);
          fdz_d = 1'b0;
        end else if (opr_q == OP_SET) begin
          // ALU returns in2, so acc is left as is
          fz_d  = (alu_out == '0);
          fdz_d = 1'b0;
        end else if (opr_q == OP_EQU) begin
          feq_d = alu_out[0];
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      in1_q       <= '0;
      op_q        <= OP_SET;
      opr_q       <= OP_NOP;
      dz_q        <= 1'b0;
      acc_q       <= '0;
      ready_q     <= 1'b1;
      res_valid_q <= 1'b0;
      fz_q        <= 1'b1;
      feq_q       <= 1'b0;
      fdz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      in1_q       <= in1_d;
      op_q        <= op_d;
      opr_q       <= opr_d;
      dz_q        <= dz_d;
      acc_q       <= acc_d;
      ready_q     <= ready_d;
      res_valid_q <= res_valid_d;
      fz_q        <= fz_d;
      feq_q       <= feq_d;
      fdz_q       <= fdz_d;
    end
  end

  assign instr_ready = ready_q;
  assign alu_in1     = in1_q;
  assign alu_in2     = acc_q;
  assign alu_op      = op_q;
  assign acc         = acc_q;
  assign res_valid   = res_valid_q;
  assign flag_zero   = fz_q;
  assign flag_eq     = feq_q;
  assign flag_dz     = fdz_q;

endmodule

// File: tb/tb_alu_acc_stage.sv
// Testbench for alu_acc_stage: behavioural ALU (x100 fixed point) plus a
// scoreboard model of acc/flags; directed steps followed by random instructions.
module tb_alu_acc_stage;
  localparam int W = 14;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                instr_valid;
  logic                instr_ready;
  logic [2:0]          instr_op;
  logic signed [W-1:0] instr_imm;
  logic signed [W-1:0] alu_in1, alu_in2, alu_out, acc;
  logic [2:0]          alu_op;
  logic                res_valid, flag_zero, flag_eq, flag_dz;

  int checks = 0;
  int errors = 0;

  // reference state
  int acc_m;
  logic fz_m, feq_m, fdz_m;

  alu_acc_stage #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_imm(instr_imm),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op), .alu_out(alu_out),
    .acc(acc), .res_valid(res_valid),
    .flag_zero(flag_zero), .flag_eq(flag_eq), .flag_dz(flag_dz)
  );

  always #5 clk = ~clk;

  function automatic int wrap(input int x);
    logic signed [W-1:0] t;
    t = x[W-1:0];
    return int'(t);
  endfunction

  // Behavioural ALU: in1 = operand, in2 = accumulator, values carry x100 gain
  int a_i, b_i, r_i;
  always_comb begin
    a_i = int'(alu_in1);
    b_i = int'(alu_in2);
    r_i = 0;
    case (alu_op)
      3'd0: r_i = b_i + a_i;
      3'd1: r_i = b_i - a_i;
      3'd2: r_i = (b_i * a_i) / 100;
      3'd3: r_i = (a_i == 0) ? 0 : (b_i * 100) / a_i;
      3'd4: r_i = a_i;
      3'd5: r_i = b_i;
      3'd6: r_i = (a_i == b_i) ? 1 : 0;
      default: r_i = 0;
    endcase
    alu_out = r_i[W-1:0];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // Reference model of one retired instruction
  task automatic model(input logic [2:0] op, input int imm);
    int r;
    if (op == 3'd3 && imm == 0) begin
`ifdef ACC_DZ_GUARD_EN
      fdz_m = 1'b1;
`endif
      return;
    end
    case (op)
      3'd0: r = acc_m + imm;
      3'd1: r = acc_m - imm;
      3'd2: r = (acc_m * imm) / 100;
      3'd3: r = (acc_m * 100) / imm;
      3'd4: r = imm;
      default: r = acc_m;
    endcase
    if (op <= 3'd5) begin
      acc_m = wrap(r);
      fz_m  = (acc_m == 0);
      fdz_m = 1'b0;
    end else if (op == 3'd6) begin
      feq_m = (imm == acc_m);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".acc"}, int'(acc), acc_m);
    chk({tag, ".in2"}, int'(alu_in2), acc_m);
    chk({tag, ".fz"}, {31'd0, flag_zero}, {31'd0, fz_m});
    chk({tag, ".feq"}, {31'd0, flag_eq}, {31'd0, feq_m});
    chk({tag, ".fdz"}, {31'd0, flag_dz}, {31'd0, fdz_m});
  endtask

  // Issue one instruction and check the full 3-cycle retire sequence
  task automatic send(input logic [2:0] op, input int imm, input string tag);
    int n;
    logic [2:0] exp_op;
    n = 0;
    @(negedge clk);
    instr_valid = 1'b1; instr_op = op; instr_imm = imm[W-1:0];
    while (!instr_ready && n < 20) begin @(negedge clk); n++; end
    chk({tag, ".ready_wait"}, {31'd0, instr_ready}, 32'd1);
    @(posedge clk);                     // accept edge N
    @(negedge clk);
    instr_valid = 1'b0;
    exp_op = (op == 3'd7) ? 3'd5 : op;
`ifdef ACC_DZ_GUARD_EN
    if (op == 3'd3 && imm == 0) exp_op = 3'd5;
`endif
    chk({tag, ".alu_op"}, {29'd0, alu_op}, {29'd0, exp_op});
    chk({tag, ".alu_in1"}, int'(alu_in1), wrap(imm));
    chk({tag, ".rv_N"}, {31'd0, res_valid}, 32'd0);
    chk({tag, ".rdy_N"}, {31'd0, instr_ready}, 32'd0);
    @(negedge clk);                     // after edge N+1
    model(op, imm);
    chk({tag, ".rv_N1"}, {31'd0, res_valid}, 32'd1);
    chk({tag, ".rdy_N1"}, {31'd0, instr_ready}, 32'd0);
    chk_state(tag);
    @(negedge clk);                     // after edge N+2
    chk({tag, ".rv_N2"}, {31'd0, res_valid}, 32'd0);
    chk({tag, ".rdy_N2"}, {31'd0, instr_ready}, 32'd1);
  endtask

  initial begin
    int n, pulses, imm_a, imm_b;
    logic [2:0] op_r;
    rst_n = 1'b0; instr_valid = 1'b0; instr_op = 3'd0; instr_imm = '0;
    acc_m = 0; fz_m = 1'b1; feq_m = 1'b0; fdz_m = 1'b0;
    #12;
    // reset state
    chk("rst.ready", {31'd0, instr_ready}, 32'd1);
    chk("rst.alu_op", {29'd0, alu_op}, 32'd5);
    chk("rst.alu_in1", int'(alu_in1), 0);
    chk("rst.rv", {31'd0, res_valid}, 32'd0);
    chk_state("rst");
    @(negedge clk); rst_n = 1'b1;

    // directed test plan sequences
    send(3'd4, 250, "load250");
    send(3'd2, 200, "mul200");
    send(3'd3, 250, "div250");
    send(3'd1, 200, "sub200");
    send(3'd4, 500, "load500");
    send(3'd6, 500, "equ500");
    send(3'd6, 100, "equ100");
    send(3'd7, 123, "nop");
    send(3'd5, 77, "set");
    send(3'd0, 8000, "add_wrap");
`ifdef ACC_DZ_GUARD_EN
    send(3'd4, 300, "load300");
    send(3'd3, 0, "div0");
    send(3'd0, 5, "add5");
`endif

    // random instructions
    for (int i = 0; i < 40; i++) begin
      op_r  = 3'($urandom_range(0, 7));
      imm_a = int'($urandom_range(0, 1200)) - 600;
`ifndef ACC_DZ_GUARD_EN
      if (op_r == 3'd3 && imm_a == 0) imm_a = 1;
`else
      if (op_r == 3'd3 && ($urandom_range(0, 3) == 0)) imm_a = 0;
`endif
      if (op_r == 3'd6 && ($urandom_range(0, 2) == 0)) imm_a = acc_m;
      send(op_r, imm_a, $sformatf("rnd%0d", i));
    end

    // back-to-back: valid held high across two instructions
    send(3'd4, 100, "b2b_pre");
    imm_a = 40; imm_b = 3;
    @(negedge clk);
    instr_valid = 1'b1; instr_op = 3'd0; instr_imm = imm_a[W-1:0];
    chk("b2b.rdyA", {31'd0, instr_ready}, 32'd1);
    @(posedge clk);                     // accept A
    @(negedge clk);
    instr_op = 3'd1; instr_imm = imm_b[W-1:0];
    chk("b2b.rdy1", {31'd0, instr_ready}, 32'd0);
    @(negedge clk);
    model(3'd0, imm_a);
    chk("b2b.rdy2", {31'd0, instr_ready}, 32'd0);
    chk("b2b.rvA", {31'd0, res_valid}, 32'd1);
    chk("b2b.accA", int'(acc), acc_m);
    @(negedge clk);
    chk("b2b.rdy3", {31'd0, instr_ready}, 32'd1);   // B accepted at next edge
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    chk("b2b.rdyB", {31'd0, instr_ready}, 32'd0);
    chk("b2b.opB", {29'd0, alu_op}, 32'd1);
    @(negedge clk);
    model(3'd1, imm_b);
    chk("b2b.rvB", {31'd0, res_valid}, 32'd1);
    chk("b2b.accB", int'(acc), acc_m);
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (res_valid) pulses++;
    end
    chk("b2b.no_dup", pulses, 0);
    chk("b2b.acc_end", int'(acc), acc_m);

    // reset during EXEC
    send(3'd4, 100, "rst_pre");
    @(negedge clk);
    instr_valid = 1'b1; instr_op = 3'd0; instr_imm = 14'sd7;
    @(posedge clk);                     // accept, now in EXEC
    #1 rst_n = 1'b0;
    #1;
    instr_valid = 1'b0;
    chk("rstx.acc", int'(acc), 0);
    chk("rstx.rv", {31'd0, res_valid}, 32'd0);
    pulses = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (res_valid) pulses++;
    end
    rst_n = 1'b1;
    acc_m = 0; fz_m = 1'b1; feq_m = 1'b0; fdz_m = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (res_valid) pulses++;
    end
    chk("rstx.no_retire", pulses, 0);
    chk("rstx.ready", {31'd0, instr_ready}, 32'd1);
    chk_state("rstx");
    send(3'd0, 7, "post_rst");

    n = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // hard time limit
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
